eio_tmr_resp: RTL and testbench
===============================

Name: eio_tmr_resp

Overview:
- Responder (slave) end of the MEM-stage external I/O bus (EIO_intf slave modport).
- Implements a memory-mapped machine timer (mtime/mtimecmp) and a software-interrupt register (msip).
- Drives timer and software interrupt request lines toward the CSR/interrupt logic.
- Sits outside the core, on the EIO bus, next to other EIO responders. Its ack/ack_fault/ack_data are OR-combined with theirs.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, byte address of register window; must be 32-byte aligned.
- TICK_DIV, 16, clk_in cycles per mtime increment (≥1).
- ACK_LAT, 1, cycles from accepted request to ack (≥1).

Ports:
- clk_in  input  1  core clock
- reset_in  input  1  synchronous, active-high reset
- req  input  1  I/O request, held by master until ack seen
- addr  input  PC_SZ  I/O byte address
- rd  input  1  1 = read
- wr  input  1  1 = write
- wr_data  input  RSZ  write data
- ack  output  1  one-cycle acknowledge
- ack_fault  output  1  fault, valid only with ack
- ack_data  output  RSZ  read data, valid with ack; 0 otherwise
- timer_irq  output  1  1 when mtime ≥ mtimecmp (unsigned 64-bit)
- sw_irq  output  1  = msip[0]

Behaviour:
- Clocking and reset:
  - One clock, clk_in. reset_in is synchronous and active-high.
  - Reset values: state=IDLE, ack=0, ack_fault=0, ack_data=0, mtime=0, prescaler=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - These reset values give timer_irq=0 and sw_irq=0.
  - Reset mid-transaction aborts it: no ack is issued and any pending write is discarded.
- Register map (offset from BASE_ADDR):
  - 0x00 mtime[31:0] (rw)
  - 0x04 mtime[63:32] (rw)
  - 0x08 mtimecmp[31:0] (rw)
  - 0x0C mtimecmp[63:32] (rw)
  - 0x10 msip: bit0 rw, bits 31:1 read 0, writes ignored
  - 0x14–0x1C reserved
- Window decode: in-window when addr[PC_SZ-1:5] == BASE_ADDR[PC_SZ-1:5]. Requests outside the window are ignored: the block stays IDLE and drives no ack.
- FSM:
  - IDLE: on req=1 and in-window, latch addr/rd/wr/wr_data.
    - ACK_LAT=1: go to ACK.
    - Otherwise go to WAIT with cnt=ACK_LAT-2.
  - WAIT: decrement cnt; go to ACK when cnt==0.
  - ACK: ack=1 for exactly one cycle, then IDLE. IDLE never accepts in the cycle ack is high.
- Result timing: ack, ack_fault and ack_data are registered and update on the edge that enters ACK.
  - ACK_LAT=1, req first high in cycle 0 → ack high in cycle 1.
  - In general, ack is high in cycle ACK_LAT.
- Fault (ack_fault=1, ack_data=0, no state change) when any of these holds:
  - addr[1:0] ≠ 0
  - reserved offset
  - rd==wr (both or neither)
- Read: ack_data = register value on the edge entering ACK.
- Write: the register updates on the same edge ack rises; ack_data=0.
- Write ordering: master must drop req in the cycle after ack; a new request may start the cycle after ACK.
- mtime:
  - Prescaler counts 0..TICK_DIV-1; on wrap, mtime += 1 (64-bit, wraps to 0 after all-ones).
  - A write to mtime_lo or mtime_hi in the same cycle as a tick takes precedence; the tick is lost for that cycle.
  - A write to one half does not alter the other half (no carry).
- timer_irq and sw_irq are registered: they reflect mtime/mtimecmp/msip one cycle after a change.

Decomposition:
- cpu_params_pkg gets the offset constants EIO_TMR_MTIME_LO/HI, EIO_TMR_CMP_LO/HI and EIO_TMR_MSIP.
- cpu_structs_pkg gets the FSM typedef EIO_RESP_STATE {IDLE, WAIT, ACK}.
- One natural sub-module: mtime_cnt (prescaler + 64-bit counter with load ports for lo/hi halves).

Test Plan:
- Reset, then read mtime_lo after 100 cycles (TICK_DIV=16): ack in cycle 1 after req; ack_data=6, ack_fault=0.
- Write mtimecmp_hi=0 and mtimecmp_lo=40 while mtime≈6: timer_irq rises exactly one cycle after mtime reaches 40, and stays high.
- Write msip=32'hFFFF_FFFF: sw_irq=1; read returns 32'h1. Write 0: sw_irq=0.
- Faults: read at BASE+0x02, read at BASE+0x18, and req with rd=wr=1 each give ack=1, ack_fault=1, ack_data=0, with registers unchanged.
- Out-of-window request (BASE+0x20) held 20 cycles: ack never asserted. ACK_LAT=4 in-window read: ack in cycle 4, exactly one cycle wide.
- Write mtime_lo=32'hFFFF_FFFF coincident with a tick, then wait one tick: mtime_hi unchanged for the write cycle and becomes 1 after the tick. Assert reset_in during WAIT: no ack, registers return to reset values.

Source files
------------

// File: rtl/eio_tmr_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eio_tmr_resp_pkg
//  Description : Shared bus widths, register offsets, FSM state type and
//                request-fault helper for the EIO timer responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package eio_tmr_resp_pkg;

    // Bus widths: byte address and register data
    localparam int PC_SZ = 32;
    localparam int RSZ   = 32;

    // Register offsets within the 32-byte window
    localparam logic [4:0] EIO_TMR_MTIME_LO = 5'h00;
    localparam logic [4:0] EIO_TMR_MTIME_HI = 5'h04;
    localparam logic [4:0] EIO_TMR_CMP_LO   = 5'h08;
    localparam logic [4:0] EIO_TMR_CMP_HI   = 5'h0C;
    localparam logic [4:0] EIO_TMR_MSIP     = 5'h10;

    // Responder FSM
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } EIO_RESP_STATE;

    // A request faults when misaligned, aimed at a reserved slot (0x14-0x1C),
    // or when it is not exactly one of read/write.
    function automatic logic eio_tmr_is_fault(input logic [4:0] off,
                                              input logic       is_rd,
                                              input logic       is_wr);
        return (off[1:0] != 2'b00) || (off > EIO_TMR_MSIP) || (is_rd == is_wr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/eio_tmr_resp_mtime_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : eio_tmr_resp_mtime_cnt
//  Description : Prescaled 64-bit machine-time counter with independent
//                32-bit load ports for the low and high halves.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_in    in   1   clock
//    reset_in  in   1   synchronous active-high reset
//    ld_lo     in   1   load mtime[31:0] from ld_data
//    ld_hi     in   1   load mtime[63:32] from ld_data
//    ld_data   in   32  load value
//    mtime     out  64  current counter value
// ============================================================================
module eio_tmr_resp_mtime_cnt #(
    parameter int TICK_DIV = 16
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        ld_lo,
    input  logic        ld_hi,
    input  logic [31:0] ld_data,
    output logic [63:0] mtime
);

    // Keep at least one prescaler bit so TICK_DIV=1 still elaborates;
    // in that case the prescaler sits at 0 and every cycle is a tick.
    localparam int          PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [63:0]   r_mtime;
    logic          w_tick;

    assign w_tick = (r_pre == PRE_MAX);
    assign mtime  = r_mtime;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_pre   <= '0;
            r_mtime <= '0;
        end else begin
            // Prescaler keeps running regardless of loads
            r_pre <= w_tick ? '0 : r_pre + 1'b1;

            // A load wins over a tick; the tick for that cycle is dropped and
            // the other half is left alone (no carry between halves).
            if (ld_lo) begin
                r_mtime[31:0] <= ld_data;
            end else if (ld_hi) begin
                r_mtime[63:32] <= ld_data;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/eio_tmr_resp.sv
`default_nettype none
// ============================================================================
//  Module      : eio_tmr_resp
//  Description : EIO bus responder exposing a memory-mapped machine timer
//                (mtime / mtimecmp) and software-interrupt bit (msip), and
//                driving the timer and software interrupt request lines.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk_in     in   1      core clock
//    reset_in   in   1      synchronous active-high reset
//    req        in   1      request, held until ack seen
//    addr       in   PC_SZ  byte address
//    rd         in   1      read
//    wr         in   1      write
//    wr_data    in   RSZ    write data
//    ack        out  1      one-cycle acknowledge
//    ack_fault  out  1      fault, valid with ack
//    ack_data   out  RSZ    read data, valid with ack, 0 otherwise
//    timer_irq  out  1      mtime >= mtimecmp (registered)
//    sw_irq     out  1      msip[0] (registered)
// ============================================================================
module eio_tmr_resp
    import eio_tmr_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          TICK_DIV  = 16,
    parameter int          ACK_LAT   = 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             req,
    input  logic [PC_SZ-1:0] addr,
    input  logic             rd,
    input  logic             wr,
    input  logic [RSZ-1:0]   wr_data,
    output logic             ack,
    output logic             ack_fault,
    output logic [RSZ-1:0]   ack_data,
    output logic             timer_irq,
    output logic             sw_irq
);

    // Wait counter holds ACK_LAT-2 down to 0
    localparam int           CW       = (ACK_LAT > 2) ? $clog2(ACK_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((ACK_LAT >= 2) ? (ACK_LAT - 2) : 0);

    EIO_RESP_STATE   r_state;
    logic [4:0]      r_off;
    logic            r_rd;
    logic            r_wr;
    logic [RSZ-1:0]  r_wdata;
    logic [CW-1:0]   r_cnt;

    logic [63:0]     r_cmp;
    logic            r_msip;
    logic [63:0]     w_mtime;

    logic            w_in_win;
    logic            w_accept;
    logic            w_fire;
    logic [4:0]      w_off;
    logic            w_rd;
    logic            w_wr;
    logic [RSZ-1:0]  w_wdata;
    logic            w_fault;
    logic            w_wen;
    logic [RSZ-1:0]  w_rdata;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_in_win = (addr[PC_SZ-1:5] == BASE_ADDR[PC_SZ-1:5]);
    assign w_accept = (r_state == IDLE) && req && w_in_win;

    // With ACK_LAT=1 the transaction completes on the accepting edge, so
    // the live bus fields are used; otherwise the latched copy is used.
    assign w_off   = (r_state == IDLE) ? addr[4:0] : r_off;
    assign w_rd    = (r_state == IDLE) ? rd        : r_rd;
    assign w_wr    = (r_state == IDLE) ? wr        : r_wr;
    assign w_wdata = (r_state == IDLE) ? wr_data   : r_wdata;

    assign w_fire  = ((ACK_LAT == 1) && w_accept) ||
                     ((r_state == WAIT) && (r_cnt == '0));
    assign w_fault = eio_tmr_is_fault(w_off, w_rd, w_wr);
    assign w_wen   = w_fire && !w_fault && w_wr;

    always_comb begin
        w_rdata = '0;
        case (w_off)
            EIO_TMR_MTIME_LO: w_rdata = w_mtime[31:0];
            EIO_TMR_MTIME_HI: w_rdata = w_mtime[63:32];
            EIO_TMR_CMP_LO:   w_rdata = r_cmp[31:0];
            EIO_TMR_CMP_HI:   w_rdata = r_cmp[63:32];
            EIO_TMR_MSIP:     w_rdata = {{(RSZ-1){1'b0}}, r_msip};
            default:          w_rdata = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Machine-time counter
    // ------------------------------------------------------------------
    eio_tmr_resp_mtime_cnt #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .ld_lo    (w_wen && (w_off == EIO_TMR_MTIME_LO)),
        .ld_hi    (w_wen && (w_off == EIO_TMR_MTIME_HI)),
        .ld_data  (w_wdata),
        .mtime    (w_mtime)
    );

    // ------------------------------------------------------------------
    // Compare / msip registers and interrupt outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_cmp     <= '1;
            r_msip    <= 1'b0;
            timer_irq <= 1'b0;
            sw_irq    <= 1'b0;
        end else begin
            if (w_wen && (w_off == EIO_TMR_CMP_LO)) r_cmp[31:0]  <= w_wdata;
            if (w_wen && (w_off == EIO_TMR_CMP_HI)) r_cmp[63:32] <= w_wdata;
            if (w_wen && (w_off == EIO_TMR_MSIP))   r_msip       <= w_wdata[0];
            timer_irq <= (w_mtime >= r_cmp);
            sw_irq    <= r_msip;
        end
    end

    // ------------------------------------------------------------------
    // Responder FSM with registered ack outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state   <= IDLE;
            r_off     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            ack       <= 1'b0;
            ack_fault <= 1'b0;
            ack_data  <= '0;
        end else begin
            ack       <= 1'b0;
            ack_fault <= 1'b0;
            ack_data  <= '0;

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_off   <= addr[4:0];
                        r_rd    <= rd;
                        r_wr    <= wr;
                        r_wdata <= wr_data;
                        r_cnt   <= CNT_INIT;
                        if (ACK_LAT != 1) r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Completion overrides the state update above
            if (w_fire) begin
                r_state   <= ACK;
                ack       <= 1'b1;
                ack_fault <= w_fault;
                ack_data  <= (w_fault || !w_rd) ? '0 : w_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eio_tmr_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eio_tmr_resp
//  Description : Directed self-checking bench for eio_tmr_resp. One instance
//                uses ACK_LAT=1, a second uses ACK_LAT=4; both TICK_DIV=16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eio_tmr_resp;

    localparam logic [31:0] BASE   = 32'hFFFF_0000;
    localparam logic [4:0]  OFF_MLO = 5'h00;
    localparam logic [4:0]  OFF_MHI = 5'h04;
    localparam logic [4:0]  OFF_CLO = 5'h08;
    localparam logic [4:0]  OFF_CHI = 5'h0C;
    localparam logic [4:0]  OFF_MSIP = 5'h10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req1, req4;
    logic [31:0] addr;
    logic        rd, wr;
    logic [31:0] wdata;

    logic        ack1, fault1, tirq1, sirq1;
    logic [31:0] data1;
    logic        ack4, fault4, tirq4, sirq4;
    logic [31:0] data4;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;   // edges since reset release (matches prescaler phase)

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    eio_tmr_resp #(.BASE_ADDR(BASE), .TICK_DIV(16), .ACK_LAT(1)) dut1 (
        .clk_in(clk), .reset_in(rst), .req(req1), .addr(addr), .rd(rd),
        .wr(wr), .wr_data(wdata), .ack(ack1), .ack_fault(fault1),
        .ack_data(data1), .timer_irq(tirq1), .sw_irq(sirq1)
    );

    eio_tmr_resp #(.BASE_ADDR(BASE), .TICK_DIV(16), .ACK_LAT(4)) dut4 (
        .clk_in(clk), .reset_in(rst), .req(req4), .addr(addr), .rd(rd),
        .wr(wr), .wr_data(wdata), .ack(ack4), .ack_fault(fault4),
        .ack_data(data4), .timer_irq(tirq4), .sw_irq(sirq4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; returns latency in cycles (-1 if no ack in 20).
    task automatic xact(input bit sel, input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, output logic [31:0] data,
                        output logic fault, output int lat);
        addr = a; rd = r; wr = w; wdata = d;
        if (sel) req4 = 1'b1; else req1 = 1'b1;
        lat = -1; data = '0; fault = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if ((sel ? ack4 : ack1) === 1'b1) begin
                lat   = i;
                data  = sel ? data4 : data1;
                fault = sel ? fault4 : fault1;
                break;
            end
        end
        req1 = 1'b0; req4 = 1'b0; rd = 1'b0; wr = 1'b0;
        step();
        check("ack_one_cycle", {63'd0, sel ? ack4 : ack1}, 64'd0);
    endtask

    task automatic rd_reg(input bit sel, input logic [4:0] off, input logic [31:0] exp,
                          input string tag);
        logic [31:0] d; logic f; int lat;
        xact(sel, BASE + {27'd0, off}, 1'b1, 1'b0, 32'h0, d, f, lat);
        check({tag, "_lat"}, 64'(lat), sel ? 64'd4 : 64'd1);
        check({tag, "_fault"}, {63'd0, f}, 64'd0);
        check({tag, "_data"}, {32'd0, d}, {32'd0, exp});
    endtask

    task automatic wr_reg(input bit sel, input logic [4:0] off, input logic [31:0] val,
                          input string tag);
        logic [31:0] d; logic f; int lat;
        xact(sel, BASE + {27'd0, off}, 1'b0, 1'b1, val, d, f, lat);
        check({tag, "_lat"}, 64'(lat), sel ? 64'd4 : 64'd1);
        check({tag, "_fault"}, {63'd0, f}, 64'd0);
        check({tag, "_data"}, {32'd0, d}, 64'd0);
    endtask

    task automatic fault_req(input logic [31:0] a, input logic r, input logic w, input string tag);
        logic [31:0] d; logic f; int lat;
        xact(1'b0, a, r, w, 32'h0000_1234, d, f, lat);
        check({tag, "_lat"}, 64'(lat), 64'd1);
        check({tag, "_fault"}, {63'd0, f}, 64'd1);
        check({tag, "_data"}, {32'd0, d}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int j0;
        bit seen;
        logic [31:0] exp4;

        rst = 1'b1; req1 = 1'b0; req4 = 1'b0;
        addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        repeat (3) step();

        // Reset state
        check("rst_ack",   {63'd0, ack1},  64'd0);
        check("rst_fault", {63'd0, fault1}, 64'd0);
        check("rst_data",  {32'd0, data1},  64'd0);
        check("rst_tirq",  {63'd0, tirq1},  64'd0);
        check("rst_sirq",  {63'd0, sirq1},  64'd0);
        check("rst_ack4",  {63'd0, ack4},  64'd0);
        rst = 1'b0;

        // mtime after 100 cycles at TICK_DIV=16 is 6
        repeat (100) step();
        rd_reg(1'b0, OFF_MLO, 32'd6, "mtime_lo_100");

        // Timer compare at 40
        wr_reg(1'b0, OFF_CHI, 32'd0,  "cmp_hi_wr");
        wr_reg(1'b0, OFF_CLO, 32'd40, "cmp_lo_wr");
        check("tirq_before", {63'd0, tirq1}, 64'd0);
        while (cyc < 640) step();
        check("tirq_at_40", {63'd0, tirq1}, 64'd0);
        step();
        check("tirq_rise", {63'd0, tirq1}, 64'd1);
        repeat (20) step();
        check("tirq_hold", {63'd0, tirq1}, 64'd1);

        // Software interrupt
        wr_reg(1'b0, OFF_MSIP, 32'hFFFF_FFFF, "msip_set");
        check("sirq_set", {63'd0, sirq1}, 64'd1);
        rd_reg(1'b0, OFF_MSIP, 32'h1, "msip_rd");
        wr_reg(1'b0, OFF_MSIP, 32'h0, "msip_clr");
        check("sirq_clr", {63'd0, sirq1}, 64'd0);

        // Faults leave registers untouched
        fault_req(BASE + 32'h02, 1'b1, 1'b0, "flt_misalign");
        fault_req(BASE + 32'h18, 1'b1, 1'b0, "flt_reserved");
        fault_req(BASE + 32'h08, 1'b1, 1'b1, "flt_rdwr");
        fault_req(BASE + 32'h0C, 1'b0, 1'b0, "flt_none");
        rd_reg(1'b0, OFF_CLO, 32'd40, "cmp_lo_kept");
        rd_reg(1'b0, OFF_CHI, 32'd0,  "cmp_hi_kept");

        // Out-of-window request held 20 cycles
        addr = BASE + 32'h20; rd = 1'b1; req1 = 1'b1; seen = 1'b0;
        repeat (20) begin
            step();
            if (ack1 !== 1'b0) seen = 1'b1;
        end
        req1 = 1'b0; rd = 1'b0;
        step();
        check("oow_no_ack", {63'd0, seen}, 64'd0);

        // ACK_LAT=4: value sampled at the edge three cycles after drive
        exp4 = 32'((cyc + 3) / 16);
        rd_reg(1'b1, OFF_MLO, exp4, "lat4_mtime_lo");

        // Write mtime_lo on a tick edge: tick lost, no carry into hi
        while ((cyc % 16) != 15) step();
        j0 = cyc;
        wr_reg(1'b0, OFF_MLO, 32'hFFFF_FFFF, "mlo_wr_tick");
        rd_reg(1'b0, OFF_MHI, 32'd0,         "mhi_after_wr");
        rd_reg(1'b0, OFF_MLO, 32'hFFFF_FFFF, "mlo_tick_lost");
        while (cyc < j0 + 17) step();
        rd_reg(1'b0, OFF_MHI, 32'd1, "mhi_carry");
        rd_reg(1'b0, OFF_MLO, 32'd0, "mlo_wrapped");

        // Reset while dut4 is in WAIT with a pending msip write
        addr = BASE + {27'd0, OFF_MSIP}; rd = 1'b0; wr = 1'b1; wdata = 32'h1; req4 = 1'b1;
        step();
        rst = 1'b1; req4 = 1'b0; wr = 1'b0; seen = 1'b0;
        step();
        if (ack4 !== 1'b0) seen = 1'b1;
        rst = 1'b0;
        repeat (6) begin
            step();
            if (ack4 !== 1'b0) seen = 1'b1;
        end
        check("rst_wait_no_ack", {63'd0, seen},  64'd0);
        check("rst_wait_sirq4",  {63'd0, sirq4}, 64'd0);
        check("rst_tirq1",       {63'd0, tirq1}, 64'd0);
        rd_reg(1'b1, OFF_MSIP, 32'h0,         "rst_msip4");
        rd_reg(1'b1, OFF_CLO,  32'hFFFF_FFFF, "rst_cmp_lo4");
        rd_reg(1'b0, OFF_CHI,  32'hFFFF_FFFF, "rst_cmp_hi1");
        rd_reg(1'b0, OFF_MHI,  32'd0,         "rst_mhi1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
